// File: rtl/pulse_sync_scheduler.sv
// Purpose : round-robin sharing of one stretched-pulse CDC channel between N
//           BUS_CLK requesters; latches request pulses and issues them one at a time.
// Latency : REQ -> PENDING 1 cycle, PENDING -> PULSE_OUT/ACK 1 cycle when idle;
//           successive issues exactly HOLDOFF cycles apart under backlog.
// Backpressure: no stall to requesters; a request hitting an already-pending
//           slot is merged and flagged in the sticky DROP bit.
//
// Ports:
//   BUS_CLK, BUS_RST   clock and synchronous active-high reset
//   REQ[N]             request pulses (each high cycle is one request)
//   DROP_CLR[N]        per-bit clear of DROP
//   PULSE_OUT          one-cycle issue into the CDC channel
//   SEL_OUT[IDXW]      index of the most recent grant, held between grants
//   ACK[N]             one-hot grant strobe, coincident with PULSE_OUT
//   PENDING[N]         latched but not yet granted requests
//   DROP[N]            sticky merged-request flags
//   BUSY               channel hold-off in progress
module pulse_sync_scheduler #(
    parameter int N       = 4,
    parameter int HOLDOFF = 32,
    parameter int IDXW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            BUS_CLK,
    input  logic            BUS_RST,
    input  logic [N-1:0]    REQ,
    input  logic [N-1:0]    DROP_CLR,
    output logic            PULSE_OUT,
    output logic [IDXW-1:0] SEL_OUT,
    output logic [N-1:0]    ACK,
    output logic [N-1:0]    PENDING,
    output logic [N-1:0]    DROP,
    output logic            BUSY
);

    localparam int CNTW = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic [IDXW-1:0] r_ptr;
    logic            r_pulse;
    logic [IDXW-1:0] r_sel;
    logic [N-1:0]    r_ack;
    logic [N-1:0]    r_pending;
    logic [N-1:0]    r_drop;
    logic            r_busy;

    logic            w_hi_vld;
    logic [IDXW-1:0] w_hi_idx;
    logic [IDXW-1:0] w_lo_idx;
    logic [IDXW-1:0] w_gidx;
    logic [IDXW-1:0] w_ptr_nxt;
    logic            w_gnt_en;
    logic [N-1:0]    w_gnt_oh;

    // Round-robin pick: lowest pending index at or above the pointer, else the
    // lowest pending index overall (wrap-around). Descending scan so the last
    // hit is the lowest index.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lo_idx = IDXW'(i);
                if (IDXW'(i) >= r_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = IDXW'(i);
                end
            end
        end
    end

    assign w_gidx    = w_hi_vld ? w_hi_idx : w_lo_idx;
    assign w_ptr_nxt = (w_gidx == IDXW'(N - 1)) ? '0 : w_gidx + IDXW'(1);

    // A grant may be issued from IDLE, or on the last hold-off cycle so that
    // back-to-back issues land exactly HOLDOFF cycles apart.
    assign w_gnt_en = (|r_pending) &&
                      ((r_state == IDLE) || (r_cnt == '0));

    always_comb begin
        w_gnt_oh = '0;
        for (int i = 0; i < N; i++) begin
            w_gnt_oh[i] = w_gnt_en && (w_gidx == IDXW'(i));
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_pulse   <= 1'b0;
            r_sel     <= '0;
            r_ack     <= '0;
            r_pending <= '0;
            r_drop    <= '0;
            r_busy    <= 1'b0;
        end else begin
            // A new request in the grant cycle re-arms the slot (set wins) and
            // is not a merge, since the old request is leaving.
            r_pending <= (r_pending & ~w_gnt_oh) | REQ;
            r_drop    <= (r_drop & ~DROP_CLR) | (REQ & r_pending & ~w_gnt_oh);
            r_pulse   <= w_gnt_en;
            r_ack     <= w_gnt_oh;

            if (w_gnt_en) begin
                r_state <= HOLD;
                r_busy  <= 1'b1;
                r_cnt   <= CNTW'(HOLDOFF - 1);
                r_sel   <= w_gidx;
                r_ptr   <= w_ptr_nxt;
            end else begin
                case (r_state)
                    HOLD: begin
                        if (r_cnt == '0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNTW'(1);
                        end
                    end
                    default: begin
                        r_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign PULSE_OUT = r_pulse;
    assign SEL_OUT   = r_sel;
    assign ACK       = r_ack;
    assign PENDING   = r_pending;
    assign DROP      = r_drop;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// Purpose : directed self-checking bench for pulse_sync_scheduler (N=4, HOLDOFF=32).
// Latency : inputs driven 1ns after a rising edge, outputs sampled 1ns after the next.
// Backpressure: not applicable; all waits on DUT events are cycle-bounded.
module tb_pulse_sync_scheduler;

    logic       BUS_CLK = 1'b0;
    logic       BUS_RST;
    logic [3:0] REQ;
    logic [3:0] DROP_CLR;
    logic       PULSE_OUT;
    logic [1:0] SEL_OUT;
    logic [3:0] ACK;
    logic [3:0] PENDING;
    logic [3:0] DROP;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    pulse_sync_scheduler #(
        .N       (4),
        .HOLDOFF (32),
        .IDXW    (2)
    ) dut (
        .BUS_CLK   (BUS_CLK),
        .BUS_RST   (BUS_RST),
        .REQ       (REQ),
        .DROP_CLR  (DROP_CLR),
        .PULSE_OUT (PULSE_OUT),
        .SEL_OUT   (SEL_OUT),
        .ACK       (ACK),
        .PENDING   (PENDING),
        .DROP      (DROP),
        .BUSY      (BUSY)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // gap: idle cycles (no inputs, no checks) before applying this vector.
    // The inputs are applied for one cycle; expectations are for the cycle after.
    typedef struct {
        int         gap;
        logic       rst;
        logic [3:0] req;
        logic [3:0] clr;
        logic       e_pulse;
        logic [3:0] e_ack;
        logic [1:0] e_sel;
        logic [3:0] e_pend;
        logic [3:0] e_drop;
        logic       e_busy;
    } vec_t;

    vec_t tv[$];

    task automatic step();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input int gap, input logic rst, input logic [3:0] req,
                       input logic [3:0] clr, input logic p, input logic [3:0] a,
                       input logic [1:0] s, input logic [3:0] pe, input logic [3:0] d,
                       input logic b);
        vec_t v;
        v = '{gap, rst, req, clr, p, a, s, pe, d, b};
        tv.push_back(v);
    endtask

    initial begin
        int         n;
        int         got;
        logic       seen;
        logic [3:0] g [3];

        BUS_RST  = 1'b1;
        REQ      = '0;
        DROP_CLR = '0;
        repeat (2) step();

        //  gap rst req      clr      pulse ack      sel   pend     drop     busy
        add(0,  1, 4'b0000, 4'b0000, 0,    4'b0000, 2'd0, 4'b0000, 4'b0000, 0); // reset state
        // single request to index 2
        add(0,  0, 4'b0100, 4'b0000, 0,    4'b0000, 2'd0, 4'b0100, 4'b0000, 0); // c1
        add(0,  0, 4'b0000, 4'b0000, 1,    4'b0100, 2'd2, 4'b0000, 4'b0000, 1); // c2 grant
        add(0,  0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd2, 4'b0000, 4'b0000, 1); // c3
        add(29, 0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd2, 4'b0000, 4'b0000, 1); // c33 last busy
        add(0,  0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd2, 4'b0000, 4'b0000, 0); // c34 idle
        add(0,  1, 4'b0000, 4'b0000, 0,    4'b0000, 2'd0, 4'b0000, 4'b0000, 0); // reset, ptr 0
        // backlog round-robin
        add(0,  0, 4'b1111, 4'b0000, 0,    4'b0000, 2'd0, 4'b1111, 4'b0000, 0); // c1
        add(0,  0, 4'b0000, 4'b0000, 1,    4'b0001, 2'd0, 4'b1110, 4'b0000, 1); // c2
        add(30, 0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd0, 4'b1110, 4'b0000, 1); // c33
        add(0,  0, 4'b0000, 4'b0000, 1,    4'b0010, 2'd1, 4'b1100, 4'b0000, 1); // c34
        add(30, 0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd1, 4'b1100, 4'b0000, 1); // c65
        add(0,  0, 4'b0000, 4'b0000, 1,    4'b0100, 2'd2, 4'b1000, 4'b0000, 1); // c66
        add(30, 0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd2, 4'b1000, 4'b0000, 1); // c97
        add(0,  0, 4'b0000, 4'b0000, 1,    4'b1000, 2'd3, 4'b0000, 4'b0000, 1); // c98
        add(30, 0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd3, 4'b0000, 4'b0000, 1); // c129
        add(0,  0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd3, 4'b0000, 4'b0000, 0); // c130
        // pointer wrapped to 0: REQ[0] granted to 0
        add(0,  0, 4'b0001, 4'b0000, 0,    4'b0000, 2'd3, 4'b0001, 4'b0000, 0);
        add(0,  0, 4'b0000, 4'b0000, 1,    4'b0001, 2'd0, 4'b0000, 4'b0000, 1); // T
        // merge / drop on index 1 during hold
        add(0,  0, 4'b0010, 4'b0000, 0,    4'b0000, 2'd0, 4'b0010, 4'b0000, 1); // T+1
        add(0,  0, 4'b0010, 4'b0000, 0,    4'b0000, 2'd0, 4'b0010, 4'b0010, 1); // T+2 merged
        add(0,  0, 4'b0000, 4'b0010, 0,    4'b0000, 2'd0, 4'b0010, 4'b0000, 1); // T+3 cleared
        add(0,  0, 4'b0010, 4'b0010, 0,    4'b0000, 2'd0, 4'b0010, 4'b0010, 1); // T+4 set wins
        add(0,  0, 4'b0000, 4'b0010, 0,    4'b0000, 2'd0, 4'b0010, 4'b0000, 1); // T+5
        add(26, 0, 4'b0000, 4'b0000, 1,    4'b0010, 2'd1, 4'b0000, 4'b0000, 1); // T+32
        add(0,  0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd1, 4'b0000, 4'b0000, 1); // T+33
        add(30, 0, 4'b0000, 4'b0000, 0,    4'b0000, 2'd1, 4'b0000, 4'b0000, 0); // T+64 single grant

        for (int i = 0; i < tv.size(); i++) begin
            BUS_RST  = 1'b0;
            REQ      = '0;
            DROP_CLR = '0;
            repeat (tv[i].gap) step();
            BUS_RST  = tv[i].rst;
            REQ      = tv[i].req;
            DROP_CLR = tv[i].clr;
            step();
            chk($sformatf("v%0d_pulse", i), 32'(PULSE_OUT), 32'(tv[i].e_pulse));
            chk($sformatf("v%0d_ack", i),   32'(ACK),       32'(tv[i].e_ack));
            chk($sformatf("v%0d_sel", i),   32'(SEL_OUT),   32'(tv[i].e_sel));
            chk($sformatf("v%0d_pend", i),  32'(PENDING),   32'(tv[i].e_pend));
            chk($sformatf("v%0d_drop", i),  32'(DROP),      32'(tv[i].e_drop));
            chk($sformatf("v%0d_busy", i),  32'(BUSY),      32'(tv[i].e_busy));
        end
        BUS_RST  = 1'b0;
        REQ      = '0;
        DROP_CLR = '0;

        // Re-request in the grant cycle of index 3 (pointer is at 2)
        REQ = 4'b1000;
        step();
        REQ = 4'b0000;
        step();
        chk("rereq_first_ack", 32'(ACK), 32'(4'b1000));
        REQ = 4'b1000;
        step();
        REQ = 4'b0000;
        chk("rereq_pending", 32'(PENDING), 32'(4'b1000));
        chk("rereq_nodrop",  32'(DROP),    32'(4'b0000));
        n = 0;
        while (!PULSE_OUT && n < 40) begin
            step();
            n++;
        end
        chk("rereq_second_pulse", 32'(PULSE_OUT), 32'(1));
        chk("rereq_second_ack",   32'(ACK),       32'(4'b1000));
        chk("rereq_spacing",      32'(n),         32'(31));
        repeat (40) step();

        // Reset in the middle of a hold with PENDING=0110
        REQ = 4'b0111;
        step();
        REQ = 4'b0000;
        step();
        chk("rst_pre_ack",  32'(ACK),     32'(4'b0001));
        chk("rst_pre_pend", 32'(PENDING), 32'(4'b0110));
        chk("rst_pre_busy", 32'(BUSY),    32'(1));
        repeat (3) step();
        BUS_RST = 1'b1;
        step();
        BUS_RST = 1'b0;
        chk("rst_outputs", {PULSE_OUT, SEL_OUT, ACK, PENDING, DROP, BUSY}, '0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (PULSE_OUT || (PENDING != 4'b0000)) seen = 1'b1;
        end
        chk("rst_no_activity", 32'(seen), 32'(0));

        // Fairness: REQ[0] held, REQ[2] pulsed once
        REQ = 4'b0101;
        step();
        REQ = 4'b0001;
        got = 0;
        n   = 0;
        while (got < 3 && n < 200) begin
            step();
            n++;
            if (PULSE_OUT) begin
                g[got] = ACK;
                got++;
            end
        end
        chk("fair_grant_count", 32'(got), 32'(3));
        if (got == 3) begin
            chk("fair_grant0", 32'(g[0]), 32'(4'b0001));
            chk("fair_grant1", 32'(g[1]), 32'(4'b0100));
            chk("fair_grant2", 32'(g[2]), 32'(4'b0001));
        end
        chk("fair_drop0", 32'(DROP), 32'(4'b0001));
        REQ = 4'b0000;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
